// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port RAM with
//            combinational read data. Port 0 is the processor and port 1 is
//            the loader/debug port. Each granted access occupies one ACCESS
//            cycle. The arbiter then returns to IDLE, and the ack pulse and
//            the read data appear in that IDLE cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   clr            in   asynchronous active-low reset
//   req0/req1      in   access request, held until the matching ack
//   we0/we1        in   1 = write, 0 = read
//   addr0/addr1    in   [DATAWIDTH] address
//   wdata0/wdata1  in   [DATAWIDTH] write data
//   ack0/ack1      out  single-cycle completion pulse
//   rdata0/rdata1  out  [DATAWIDTH] registered read data, held between reads
//   mem_address    out  [DATAWIDTH] RAM address, zero when idle
//   mem_data_in    out  [DATAWIDTH] RAM write data, zero when idle
//   mem_write      out  RAM write strobe, only during a write access
//   mem_data_out   in   [DATAWIDTH] RAM combinational read data
//   busy           out  high during either ACCESS state
// ============================================================================
module mem_arbiter #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  // processor port
  input  logic                 req0,
  input  logic                 we0,
  input  logic [DATAWIDTH-1:0] addr0,
  input  logic [DATAWIDTH-1:0] wdata0,
  output logic                 ack0,
  output logic [DATAWIDTH-1:0] rdata0,
  // loader / debug port
  input  logic                 req1,
  input  logic                 we1,
  input  logic [DATAWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] wdata1,
  output logic                 ack1,
  output logic [DATAWIDTH-1:0] rdata1,
  // RAM side
  output logic [DATAWIDTH-1:0] mem_address,
  output logic [DATAWIDTH-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [DATAWIDTH-1:0] mem_data_out,
  // status
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS0 = 2'd1,
    ST_ACCESS1 = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_last_gnt;
  logic                   r_we;
  logic [DATAWIDTH-1:0]   r_addr;
  logic [DATAWIDTH-1:0]   r_wdata;
  logic                   r_ack0;
  logic                   r_ack1;
  logic [DATAWIDTH-1:0]   r_rdata0;
  logic [DATAWIDTH-1:0]   r_rdata1;

  logic                   w_elig0;
  logic                   w_elig1;
  logic                   w_grant0;
  logic                   w_grant1;
  logic                   w_busy;

  // A requester keeps req high through the cycle in which its ack is
  // visible. Masking with the registered ack stops that stale request from
  // starting a second access.
  assign w_elig0 = req0 & ~r_ack0;
  assign w_elig1 = req1 & ~r_ack1;

  // On contention, the port that was not granted last wins. Reset leaves
  // last_gnt at 1, so port 0 takes the first contention.
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_gnt);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_gnt);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      // The acks are single-cycle pulses. They are cleared every cycle and
      // set only on the edge that leaves an ACCESS state.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant0) begin
            r_state    <= ST_ACCESS0;
            r_last_gnt <= 1'b0;
            r_we       <= we0;
            r_addr     <= addr0;
            r_wdata    <= wdata0;
          end else if (w_grant1) begin
            r_state    <= ST_ACCESS1;
            r_last_gnt <= 1'b1;
            r_we       <= we1;
            r_addr     <= addr1;
            r_wdata    <= wdata1;
          end
        end
        ST_ACCESS0: begin
          r_state <= ST_IDLE;
          r_ack0  <= 1'b1;
          if (!r_we) begin
            r_rdata0 <= mem_data_out;
          end
        end
        ST_ACCESS1: begin
          r_state <= ST_IDLE;
          r_ack1  <= 1'b1;
          if (!r_we) begin
            r_rdata1 <= mem_data_out;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM-side outputs are decoded from the state register and the
  // latched request only. They therefore cannot glitch on req inputs, and
  // they fall as soon as clr is asserted.
  assign w_busy      = (r_state == ST_ACCESS0) || (r_state == ST_ACCESS1);
  assign busy        = w_busy;
  assign mem_write   = w_busy & r_we;
  assign mem_address = w_busy ? r_addr  : '0;
  assign mem_data_in = w_busy ? r_wdata : '0;

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. It provides a behavioural
//            RAM, runs directed scenarios, and runs randomized two-port
//            traffic. The randomized traffic is checked against a
//            transaction-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr;
  logic          req0, we0, ack0, req1, we1, ack1;
  logic [DW-1:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [DW-1:0] mem_address, mem_data_in, mem_data_out;
  logic          mem_write, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.DATAWIDTH(DW)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Behavioural RAM. The DUT writes it through mem_write. The bench
  // preloads it through a side port, and only while the DUT is idle.
  logic [DW-1:0] ram [0:255];
  logic          pre_we = 1'b0;
  logic [DW-1:0] pre_addr = '0, pre_data = '0;
  always @(posedge clk) begin
    if (mem_write) ram[mem_address] <= mem_data_in;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_data_out = ram[mem_address];

  // Reference model: expected RAM contents and expected read registers.
  logic [DW-1:0] model_mem [0:255];
  logic [DW-1:0] exp_rd0, exp_rd1;
  int pass_cnt = 0;
  int total_cnt = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    model_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    #2;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = 8'(i * 37 + 11);
      model_mem[i] = 8'(i * 37 + 11);
    end
    @(negedge clk);
    pre_we = 1'b0;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL reset_ack0: got %b expected 0", ack0); else pass_cnt++;
    total_cnt++; if (ack1 !== 1'b0) $display("FAIL reset_ack1: got %b expected 0", ack1); else pass_cnt++;
    total_cnt++; if (rdata0 !== 8'h00) $display("FAIL reset_rdata0: got %h expected 00", rdata0); else pass_cnt++;
    total_cnt++; if (rdata1 !== 8'h00) $display("FAIL reset_rdata1: got %h expected 00", rdata1); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b expected 0", mem_write); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h00) $display("FAIL reset_mem_address: got %h expected 00", mem_address); else pass_cnt++;
    total_cnt++; if (mem_data_in !== 8'h00) $display("FAIL reset_mem_data_in: got %h expected 00", mem_data_in); else pass_cnt++;
    clr = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic test_single_read;
    preload(8'h10, 8'hA5);
    req0 = 1; we0 = 0; addr0 = 8'h10; wdata0 = 8'($urandom);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL read_busy: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h10) $display("FAIL read_addr: got %h expected 10", mem_address); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL read_no_write: got %b expected 0", mem_write); else pass_cnt++;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL read_early_ack: got %b expected 0", ack0); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ack0 !== 1'b1) $display("FAIL read_ack0: got %b expected 1", ack0); else pass_cnt++;
    total_cnt++; if (rdata0 !== 8'hA5) $display("FAIL read_rdata0: got %h expected a5", rdata0); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL read_no_write2: got %b expected 0", mem_write); else pass_cnt++;
    exp_rd0 = 8'hA5;
    req0 = 0;
    @(negedge clk);
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL read_ack_pulse: got %b expected 0", ack0); else pass_cnt++;
  endtask

  task automatic test_loader_write;
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
    @(negedge clk);
    total_cnt++; if (mem_write !== 1'b1) $display("FAIL wr_strobe: got %b expected 1", mem_write); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h20) $display("FAIL wr_addr: got %h expected 20", mem_address); else pass_cnt++;
    total_cnt++; if (mem_data_in !== 8'h3C) $display("FAIL wr_data: got %h expected 3c", mem_data_in); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b1) $display("FAIL wr_ack1: got %b expected 1", ack1); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL wr_strobe_len: got %b expected 0", mem_write); else pass_cnt++;
    total_cnt++; if (rdata1 !== exp_rd1) $display("FAIL wr_rdata1_hold: got %h expected %h", rdata1, exp_rd1); else pass_cnt++;
    model_mem[8'h20] = 8'h3C;
    req1 = 0;
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b0) $display("FAIL wr_ack_pulse: got %b expected 0", ack1); else pass_cnt++;
    req1 = 1; we1 = 0; addr1 = 8'h20; wdata1 = 8'($urandom);
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b1) $display("FAIL rb_ack1: got %b expected 1", ack1); else pass_cnt++;
    total_cnt++; if (rdata1 !== 8'h3C) $display("FAIL rb_rdata1: got %h expected 3c", rdata1); else pass_cnt++;
    total_cnt++; if (rdata0 !== exp_rd0) $display("FAIL rb_rdata0_hold: got %h expected %h", rdata0, exp_rd0); else pass_cnt++;
    exp_rd1 = 8'h3C;
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_stale_request;
    logic [DW-1:0] a;
    a = 8'($urandom_range(0, 255));
    req0 = 1; we0 = 0; addr0 = a;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ack0 !== 1'b1) $display("FAIL stale_ack0: got %b expected 1", ack0); else pass_cnt++;
    total_cnt++; if (rdata0 !== model_mem[a]) $display("FAIL stale_rdata0: got %h expected %h", rdata0, model_mem[a]); else pass_cnt++;
    exp_rd0 = model_mem[a];
    // req0 stays high through the ack cycle and the edge that ends it
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL stale_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL stale_ack_again: got %b expected 0", ack0); else pass_cnt++;
    req0 = 0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL stale_busy2: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_dropped_request;
    logic [DW-1:0] a1, orig;
    a1 = 8'($urandom_range(0, 63));
    orig = model_mem[8'h50];
    req1 = 1; we1 = 0; addr1 = a1;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 8'h50; wdata0 = 8'hEE;
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b1) $display("FAIL drop_ack1: got %b expected 1", ack1); else pass_cnt++;
    total_cnt++; if (rdata1 !== model_mem[a1]) $display("FAIL drop_rdata1: got %h expected %h", rdata1, model_mem[a1]); else pass_cnt++;
    exp_rd1 = model_mem[a1];
    req0 = 0; req1 = 0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL drop_ack0: got %b expected 0", ack0); else pass_cnt++;
    total_cnt++; if (ram[8'h50] !== orig) $display("FAIL drop_ram: got %h expected %h", ram[8'h50], orig); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    preload(8'h30, 8'h11);
    req1 = 1; we1 = 1; addr1 = 8'h30; wdata1 = 8'h77;
    @(negedge clk);
    total_cnt++; if (mem_write !== 1'b1) $display("FAIL mr_write_before: got %b expected 1", mem_write); else pass_cnt++;
    clr = 1'b0;
    #1;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL mr_write_drop: got %b expected 0", mem_write); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mr_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (mem_address !== 8'h00) $display("FAIL mr_addr: got %h expected 00", mem_address); else pass_cnt++;
    total_cnt++; if (mem_data_in !== 8'h00) $display("FAIL mr_data: got %h expected 00", mem_data_in); else pass_cnt++;
    total_cnt++; if ({rdata1, rdata0} !== 16'h0000) $display("FAIL mr_rdata: got %h expected 0000", {rdata1, rdata0}); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b0) $display("FAIL mr_no_ack1: got %b expected 0", ack1); else pass_cnt++;
    total_cnt++; if (ram[8'h30] !== 8'h11) $display("FAIL mr_ram: got %h expected 11", ram[8'h30]); else pass_cnt++;
    req1 = 0; we1 = 0;
    clr = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
    @(negedge clk);
    total_cnt++; if ({ack1, busy} !== 2'b00) $display("FAIL mr_after: got %b expected 00", {ack1, busy}); else pass_cnt++;
    total_cnt++; if (ram[8'h30] !== 8'h11) $display("FAIL mr_ram_after: got %h expected 11", ram[8'h30]); else pass_cnt++;
  endtask

  task automatic test_contention;
    logic [DW-1:0] a0, a1;
    logic e0, e1;
    a0 = 8'($urandom_range(0, 127));
    a1 = 8'($urandom_range(128, 255));
    @(negedge clk);
    clr = 1'b0;
    req0 = 1; we0 = 0; addr0 = a0;
    req1 = 1; we1 = 0; addr1 = a1;
    @(negedge clk);
    clr = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
    // Grant order 0,1,0,1: accesses on odd cycles, acks alternate on even cycles
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      e0 = (n % 4 == 2);
      e1 = (n % 4 == 0);
      if (e0) exp_rd0 = model_mem[a0];
      if (e1) exp_rd1 = model_mem[a1];
      total_cnt++; if ({ack0, ack1} !== {e0, e1}) $display("FAIL cont_acks n=%0d: got %b expected %b", n, {ack0, ack1}, {e0, e1}); else pass_cnt++;
      total_cnt++; if (busy !== 1'(n % 2)) $display("FAIL cont_busy n=%0d: got %b expected %b", n, busy, 1'(n % 2)); else pass_cnt++;
      total_cnt++; if ({rdata0, rdata1} !== {exp_rd0, exp_rd1}) $display("FAIL cont_rdata n=%0d: got %h expected %h", n, {rdata0, rdata1}, {exp_rd0, exp_rd1}); else pass_cnt++;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL cont_end_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_random_traffic;
    logic          pend [2];
    logic          pw   [2];
    logic [DW-1:0] pa   [2];
    logic [DW-1:0] pd   [2];
    int            age  [2];
    logic [1:0]    ackv;
    logic [DW-1:0] rdv  [2];
    for (int p = 0; p < 2; p++) begin pend[p] = 0; age[p] = 0; pw[p] = 0; pa[p] = '0; pd[p] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      ackv = {ack1, ack0};
      rdv[0] = rdata0; rdv[1] = rdata1;
      total_cnt++; if (ackv === 2'b11) $display("FAIL rnd_dual_ack cyc=%0d: got %b expected not 11", cyc, ackv); else pass_cnt++;
      total_cnt++; if (mem_write === 1'b1 && busy !== 1'b1) $display("FAIL rnd_write_idle cyc=%0d: got busy=%b expected 1", cyc, busy); else pass_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (ackv[p]) begin
          total_cnt++; if (!pend[p]) $display("FAIL rnd_spurious_ack%0d cyc=%0d: got ack expected none", p, cyc); else pass_cnt++;
          if (pend[p]) begin
            if (pw[p]) model_mem[pa[p]] = pd[p];
            else if (p == 0) exp_rd0 = model_mem[pa[p]];
            else exp_rd1 = model_mem[pa[p]];
          end
          pend[p] = 0;
          if (p == 0) req0 = 0; else req1 = 0;
        end else if (pend[p]) begin
          age[p]++;
          if (age[p] > 6) begin
            total_cnt++;
            $display("FAIL rnd_timeout%0d cyc=%0d: got no ack expected ack within 6 cycles", p, cyc);
            pend[p] = 0;
            if (p == 0) req0 = 0; else req1 = 0;
          end
        end
      end
      total_cnt++; if (rdv[0] !== exp_rd0) $display("FAIL rnd_rdata0 cyc=%0d: got %h expected %h", cyc, rdv[0], exp_rd0); else pass_cnt++;
      total_cnt++; if (rdv[1] !== exp_rd1) $display("FAIL rnd_rdata1 cyc=%0d: got %h expected %h", cyc, rdv[1], exp_rd1); else pass_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && !ackv[p] && cyc < 580 && $urandom_range(0, 2) == 0) begin
          pend[p] = 1; age[p] = 0;
          pw[p] = 1'($urandom); pa[p] = 8'($urandom_range(0, 15)); pd[p] = 8'($urandom);
          if (p == 0) begin req0 = 1; we0 = pw[p]; addr0 = pa[p]; wdata0 = pd[p]; end
          else begin req1 = 1; we1 = pw[p]; addr1 = pa[p]; wdata1 = pd[p]; end
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (ram[i] !== model_mem[i]) $display("FAIL rnd_ram[%0d]: got %h expected %h", i, ram[i], model_mem[i]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_loader_write();
    test_stale_request();
    test_dropped_request();
    test_mid_reset();
    test_contention();
    test_random_traffic();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, giving the data and address width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req0  input  1  processor request; held high until ack0.
REQ-005 SHALL have port we0  input  1  processor write enable (1=write, 0=read); stable while req0 high.
REQ-006 SHALL have port addr0  input  DATAWIDTH  processor address; stable while req0 high.
REQ-007 SHALL have port wdata0  input  DATAWIDTH  processor write data; stable while req0 high.
REQ-008 SHALL have port ack0  output  1  one-cycle completion pulse to the processor.
REQ-009 SHALL have port rdata0  output  DATAWIDTH  registered read data to the processor.
REQ-010 SHALL have ports req1, we1, addr1, wdata1, ack1, rdata1 identical to REQ-004..REQ-009, for the loader/debug port.
REQ-011 SHALL have port mem_address  output  DATAWIDTH  to RAM address.
REQ-012 SHALL have port mem_data_in  output  DATAWIDTH  to RAM write data.
REQ-013 SHALL have port mem_write  output  1  to RAM write strobe; RAM writes on the clk edge while this is high.
REQ-014 SHALL have port mem_data_out  input  DATAWIDTH  RAM combinational read data.
REQ-015 SHALL have port busy  output  1  high while in an ACCESS state.

Function
REQ-016 SHALL implement states IDLE, ACCESS0 and ACCESS1, plus a 1-bit last_gnt register.
REQ-017 SHALL, in IDLE, treat reqN as eligible only when reqN=1 and ackN=0 (masks the request still high in the ack cycle).
REQ-018 SHALL, in IDLE with exactly one eligible requester N, move to ACCESSN on the next edge and latch addrN, weN and wdataN.
REQ-019 SHALL, in IDLE with both eligible, grant the port not equal to last_gnt (round-robin).
REQ-020 SHALL set last_gnt to N on entry to ACCESSN.
REQ-021 SHALL, in ACCESSN, drive mem_address and mem_data_in from the latched values and mem_write = latched we.
REQ-022 SHALL, on the edge leaving ACCESSN, return to IDLE unconditionally and pulse ackN high for exactly one cycle.
REQ-023 SHALL, on that same edge, load rdataN with mem_data_out when the latched we=0; rdataN is unchanged on writes.
REQ-024 SHALL hold rdataN between accesses; the other port's rdata is never modified.
REQ-025 SHALL, in IDLE, drive mem_address=0, mem_data_in=0 and mem_write=0.
REQ-026 SHALL decode mem_write and busy combinationally from state only, so they are glitch-free with respect to req inputs.
REQ-027 SHALL meet the following timing: request sampled at edge k -> ACCESS during cycle k..k+1 -> ack and rdata valid after edge k+1; one access per 2 cycles maximum.
REQ-028 SHALL ignore a request that drops before grant, with no side effects.
REQ-029 SHALL ignore changes to addr, we or wdata after latching until ack.
REQ-030 SHALL never assert ack0 and ack1 in the same cycle.
REQ-031 SHALL never assert mem_write outside ACCESS0/ACCESS1.

Reset
REQ-032 SHALL, while clr=0, immediately force: state=IDLE, last_gnt=1, ack0=ack1=0, rdata0=rdata1=0, and the latched address/data/we = 0.
REQ-033 SHALL, as a consequence of REQ-032, deassert mem_write and busy without waiting for a clock edge.
REQ-034 SHALL, on clr asserted mid-ACCESS, abort the access with no ack issued and no RAM write on any later edge.
REQ-035 SHALL, after clr rises, arbitrate normally from the first edge; port 0 wins the first contention.

Verification
REQ-036 SHALL be covered by a single processor read test: RAM[0x10]=0xA5, req0=1 we0=0 addr0=0x10 -> ack0 pulse 2 edges later, rdata0=0xA5, mem_write never high.
REQ-037 SHALL be covered by a loader write test: req1=1 we1=1 addr1=0x20 wdata1=0x3C -> mem_write high exactly 1 cycle with mem_address=0x20 and mem_data_in=0x3C; then a read of 0x20 returns 0x3C.
REQ-038 SHALL be covered by a contention test: req0 and req1 both held high from reset -> grant order 0,1,0,1, ack pulses alternate every 2 cycles, never simultaneous.
REQ-039 SHALL be covered by a stale-request test: req0 held 1 cycle past ack0 with req1 low -> no second access starts in that cycle.
REQ-040 SHALL be covered by a mid-access reset test: clr pulled low during ACCESS1 write -> mem_write falls immediately, no ack1, RAM location unchanged, all outputs 0.
